prover_compute_h_seqmux: RTL



---
 rtl/prover_compute_h_seqmux.sv | 113 +++++++++++
 1 files changed

// File: rtl/prover_compute_h_seqmux.sv
// Captures nInputs field elements on an accepted start strobe, then streams them
// nOutputs per beat to the compute_h multiplier lanes under a valid/ready handshake.
module prover_compute_h_seqmux #(
  parameter int F_NBITS    = 16,
  parameter int nInputs    = 8,
  parameter int nOutputs   = 2,
  parameter int nGroups    = (nInputs + nOutputs - 1) / nOutputs,
  parameter int nCountBits = nGroups > 1 ? $clog2(nGroups) : 1
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         en,
  input  logic [nInputs*F_NBITS-1:0]   vals_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [nOutputs*F_NBITS-1:0]  vals_out,
  output logic [nCountBits-1:0]        count_out,
  output logic                         last_out,
  output logic                         ready,
  output logic                         ready_pulse
);

  localparam int NGroupsCalc    = (nOutputs > 0) ? (nInputs + nOutputs - 1) / nOutputs : 1;
  localparam int NCountBitsCalc = NGroupsCalc > 1 ? $clog2(NGroupsCalc) : 1;
  localparam logic [nCountBits-1:0] LastCount = nCountBits'(nGroups - 1);

  if (nInputs < 2) begin : g_err_ninputs_lt_2
    $error("prover_compute_h_seqmux: nInputs must be >= 2");
  end
  if (nOutputs < 1) begin : g_err_noutputs_lt_1
    $error("prover_compute_h_seqmux: nOutputs must be >= 1");
  end
  if (nOutputs > nInputs) begin : g_err_noutputs_gt_ninputs
    $error("prover_compute_h_seqmux: nOutputs must not exceed nInputs");
  end
  if (nGroups != NGroupsCalc || nCountBits != NCountBitsCalc) begin : g_err_derived_override
    $error("prover_compute_h_seqmux: nGroups/nCountBits are derived and must not be overridden");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q;
  logic [nCountBits-1:0] count_q;
  logic [F_NBITS-1:0]   stored_q [nInputs];
  logic                 ready_pulse_q;

  // NOTE: the capture array is reset too, so vals_out is a known zero after reset
  // and no stale operand from an abandoned transaction can leak out later.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      ready_pulse_q <= 1'b0;
      for (int i = 0; i < nInputs; i++) stored_q[i] <= '0;
    end else begin
      ready_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            for (int i = 0; i < nInputs; i++) stored_q[i] <= vals_in[i*F_NBITS +: F_NBITS];
            count_q <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            if (count_q == LastCount) begin
              count_q       <= '0;
              state_q       <= S_IDLE;
              ready_pulse_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Per-lane, per-group source table; slots past nInputs are constant zero padding.
  logic [F_NBITS-1:0] lane_src [nOutputs][nGroups];

  for (genvar j = 0; j < nOutputs; j++) begin : g_lane
    for (genvar g = 0; g < nGroups; g++) begin : g_grp
      if (g * nOutputs + j < nInputs) begin : g_data
        assign lane_src[j][g] = stored_q[g*nOutputs + j];
      end else begin : g_pad
        assign lane_src[j][g] = '0;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred
  // when no group matches count_q.
  always_comb begin
    vals_out = '0;
    if (state_q == S_RUN) begin
      for (int j = 0; j < nOutputs; j++) begin
        for (int g = 0; g < nGroups; g++) begin
          if (count_q == nCountBits'(g)) vals_out[j*F_NBITS +: F_NBITS] = lane_src[j][g];
        end
      end
    end
  end

  assign out_valid   = (state_q == S_RUN);
  assign ready       = (state_q == S_IDLE);
  assign ready_pulse = ready_pulse_q;
  assign count_out   = count_q;
  assign last_out    = (state_q == S_RUN) && (count_q == LastCount);

endmodule
